pc_branch_unit: RTL and testbench

- Parametrised program-counter and branch-resolution block for the LEGv8 datapath.
- Owns the PC register and drives a fetch request/acknowledge handshake.
- Accepts resolved branch information from execute: B, CBZ, CBNZ, BR.
- Computes the target, redirects the PC, and pulses a one-cycle pipeline flush.
- Replaces the ad-hoc AND-gate / branch-mux / adder path with a registered, reset-safe unit.

---
 rtl/pc_branch_pkg.sv | 7 +
 rtl/branch_target_calc.sv | 21 ++
 rtl/pc_branch_unit.sv | 61 ++++++
 tb/tb_pc_branch_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pc_branch_pkg.sv
// pc_branch_pkg: shared encodings and constants for the PC / branch unit.
package pc_branch_pkg;
  typedef enum logic [1:0] {BR_B = 2'b00, BR_CBZ = 2'b01, BR_CBNZ = 2'b10, BR_REG = 2'b11} br_mode_e;
  typedef enum logic [1:0] {HOLD, RUN, REDIRECT} state_e;
  localparam int INSTR_BYTES = 4;
  localparam int INSTR_SHIFT = 2;
endpackage

// File: rtl/branch_target_calc.sv
// branch_target_calc: branch target (PC-relative or register) and BR word-alignment check.
module branch_target_calc
  import pc_branch_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int IMM_W  = 26
) (
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [IMM_W-1:0]  br_imm,
  input  logic [1:0]        br_mode,
  input  logic [ADDR_W-1:0] br_reg,
  output logic [ADDR_W-1:0] target,
  output logic              aligned
);
  logic [ADDR_W-1:0] offset;
  always_comb begin
    offset  = {{(ADDR_W-IMM_W){br_imm[IMM_W-1]}}, br_imm} << INSTR_SHIFT;
    target  = br_mode == BR_REG ? br_reg : br_pc + offset;
    aligned = br_reg[INSTR_SHIFT-1:0] == '0;
  end
endmodule

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: PC register, fetch handshake and branch redirect with one-cycle flush.
module pc_branch_unit
  import pc_branch_pkg::*;
#(
  parameter int              ADDR_W   = 64,
  parameter int              IMM_W    = 26,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_ack,
  input  logic              br_valid,
  input  logic [1:0]        br_mode,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [IMM_W-1:0]  br_imm,
  input  logic [ADDR_W-1:0] br_reg,
  input  logic              zero,
  output logic [ADDR_W-1:0] pc_out,
  output logic              flush,
  output logic              taken,
  output logic              align_err,
  output logic [CNT_W-1:0]  taken_count
);
  state_e state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx, target;
  logic aligned, cond, take, misalign;
  branch_target_calc #(.ADDR_W(ADDR_W), .IMM_W(IMM_W)) u_calc (
    .br_pc(br_pc), .br_imm(br_imm), .br_mode(br_mode), .br_reg(br_reg),
    .target(target), .aligned(aligned)
  );
  // Branches are only honoured in RUN; during REDIRECT they belong to the squashed path.
  always_comb begin
    cond      = br_mode == BR_B ? 1'b1 : br_mode == BR_CBZ ? zero : br_mode == BR_CBNZ ? !zero : aligned;
    take      = state == RUN && br_valid && cond;
    misalign  = state == RUN && br_valid && br_mode == BR_REG && !aligned;
    fetch_req = state == RUN && !stall;
    flush     = state == REDIRECT;
    pc_nx     = take ? target : (fetch_req && fetch_ack) ? pc + ADDR_W'(INSTR_BYTES) : pc;
    state_nx  = (state == RUN && take) ? REDIRECT : RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= HOLD;
      pc          <= RESET_PC;
      taken       <= 1'b0;
      align_err   <= 1'b0;
      taken_count <= '0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      taken     <= take;
      align_err <= misalign;
      if (take && taken_count != '1) taken_count <= taken_count + 1'b1;
    end
  assign pc_out     = pc;
  assign fetch_addr = pc;
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: directed self-checking bench for pc_branch_unit (CNT_W=2 to reach saturation).
module tb_pc_branch_unit;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, fetch_ack = 1'b0, br_valid = 1'b0, zero = 1'b0;
  logic [1:0] br_mode = 2'b00;
  logic [63:0] br_pc = '0, br_reg = '0;
  logic [25:0] br_imm = '0;
  logic fetch_req, flush, taken, align_err;
  logic [63:0] fetch_addr, pc_out;
  logic [1:0] taken_count;
  int tests = 0, fails = 0;

  pc_branch_unit #(.ADDR_W(64), .IMM_W(26), .RESET_PC(64'h0), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .br_valid(br_valid), .br_mode(br_mode), .br_pc(br_pc),
    .br_imm(br_imm), .br_reg(br_reg), .zero(zero), .pc_out(pc_out), .flush(flush),
    .taken(taken), .align_err(align_err), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_to_run;
    stall = 0; fetch_ack = 0; br_valid = 0; zero = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset;
    stall = 0; fetch_ack = 1; br_valid = 0;
    rst_n = 0;
    tick();
    tests++; if ({fetch_req, flush, taken, align_err} !== 4'b0 || pc_out !== 64'h0 || taken_count !== 2'd0) begin
      fails++; $display("FAIL reset_values got req%b fl%b tk%b ae%b pc%h cnt%0d want all zero", fetch_req, flush, taken, align_err, pc_out, taken_count);
    end
    rst_n = 1;
    #1;
    tests++; if (fetch_req !== 1'b0 || pc_out !== 64'h0) begin
      fails++; $display("FAIL hold_quiet got req %b pc %h want 0 0", fetch_req, pc_out);
    end
    tick();
    tests++; if (fetch_req !== 1'b1 || fetch_addr !== 64'h0) begin
      fails++; $display("FAIL first_fetch got req %b addr %h want 1 0", fetch_req, fetch_addr);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      tests++; if (pc_out !== 64'(4 * i)) begin
        fails++; $display("FAIL seq_advance got %h want %h", pc_out, 64'(4 * i));
      end
    end
  endtask

  task automatic test_stall;
    reset_to_run();
    br_valid = 1; br_mode = 2'b00; br_pc = 64'h0; br_imm = 26'd64;
    tick();
    br_valid = 0; stall = 1; fetch_ack = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (fetch_req !== 1'b0 || pc_out !== 64'h100) begin
        fails++; $display("FAIL stall_hold got req %b pc %h want 0 100", fetch_req, pc_out);
      end
    end
    stall = 0;
    #1;
    tests++; if (fetch_req !== 1'b1) begin
      fails++; $display("FAIL stall_release_req got %b want 1", fetch_req);
    end
    tick();
    tests++; if (pc_out !== 64'h104) begin
      fails++; $display("FAIL stall_resume got %h want 104", pc_out);
    end
  endtask

  task automatic test_cbz;
    reset_to_run();
    fetch_ack = 1;
    br_valid = 1; br_mode = 2'b01; zero = 1; br_pc = 64'h40; br_imm = 26'h3FFFFFC;
    tick();
    br_valid = 0;
    tests++; if (pc_out !== 64'h30 || flush !== 1'b1 || taken !== 1'b1 || taken_count !== 2'd1 || fetch_req !== 1'b0) begin
      fails++; $display("FAIL cbz_redirect got pc %h fl %b tk %b cnt %0d req %b want 30 1 1 1 0", pc_out, flush, taken, taken_count, fetch_req);
    end
    tick();
    tests++; if (fetch_req !== 1'b1 || fetch_addr !== 64'h30 || flush !== 1'b0 || taken !== 1'b0) begin
      fails++; $display("FAIL cbz_refetch got req %b addr %h fl %b tk %b want 1 30 0 0", fetch_req, fetch_addr, flush, taken);
    end
    tick();
    tests++; if (pc_out !== 64'h34) begin
      fails++; $display("FAIL cbz_after got %h want 34", pc_out);
    end
  endtask

  task automatic test_not_taken;
    reset_to_run();
    fetch_ack = 1;
    br_valid = 1; br_mode = 2'b10; zero = 1; br_pc = 64'h0; br_imm = 26'd100;
    tick();
    tests++; if (pc_out !== 64'h4 || flush !== 1'b0 || taken !== 1'b0) begin
      fails++; $display("FAIL cbnz_not_taken got pc %h fl %b tk %b want 4 0 0", pc_out, flush, taken);
    end
    br_mode = 2'b11; br_reg = 64'h202;
    tick();
    tests++; if (pc_out !== 64'h8 || align_err !== 1'b1 || flush !== 1'b0 || taken !== 1'b0 || taken_count !== 2'd0) begin
      fails++; $display("FAIL br_misaligned got pc %h ae %b fl %b tk %b cnt %0d want 8 1 0 0 0", pc_out, align_err, flush, taken, taken_count);
    end
    br_reg = 64'h300;
    tick();
    br_valid = 0;
    tests++; if (pc_out !== 64'h300 || align_err !== 1'b0 || flush !== 1'b1 || taken_count !== 2'd1) begin
      fails++; $display("FAIL br_taken got pc %h ae %b fl %b cnt %0d want 300 0 1 1", pc_out, align_err, flush, taken_count);
    end
  endtask

  task automatic test_back_to_back;
    reset_to_run();
    fetch_ack = 1;
    br_valid = 1; br_mode = 2'b00; br_pc = 64'h10; br_imm = 26'd4;
    tick();
    tests++; if (pc_out !== 64'h20 || flush !== 1'b1) begin
      fails++; $display("FAIL b2b_first got pc %h fl %b want 20 1", pc_out, flush);
    end
    br_pc = 64'h80; br_imm = 26'd8;
    tick();
    br_valid = 0;
    tests++; if (pc_out !== 64'h20 || flush !== 1'b0 || taken !== 1'b0 || taken_count !== 2'd1) begin
      fails++; $display("FAIL b2b_ignored got pc %h fl %b tk %b cnt %0d want 20 0 0 1", pc_out, flush, taken, taken_count);
    end
  endtask

  task automatic test_wrap;
    reset_to_run();
    br_valid = 1; br_mode = 2'b00; br_pc = 64'h0; br_imm = '1;
    tick();
    br_valid = 0; fetch_ack = 1;
    tests++; if (pc_out !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      fails++; $display("FAIL wrap_target got %h want fffffffffffffffc", pc_out);
    end
    tick();
    tick();
    tests++; if (pc_out !== 64'h0) begin
      fails++; $display("FAIL wrap_advance got %h want 0", pc_out);
    end
  endtask

  task automatic test_saturate_and_reset;
    reset_to_run();
    br_mode = 2'b00; br_pc = 64'h0;
    for (int i = 0; i < 5; i++) begin
      br_valid = 1; br_imm = 26'(i + 1);
      tick();
      br_valid = 0;
      tests++; if (taken_count !== 2'((i + 1 > 3) ? 3 : i + 1)) begin
        fails++; $display("FAIL sat_count got %0d want %0d", taken_count, (i + 1 > 3) ? 3 : i + 1);
      end
      tick();
    end
    br_valid = 1; br_imm = 26'd16;
    tick();
    br_valid = 0;
    #2;
    rst_n = 0;
    #1;
    tests++; if (flush !== 1'b0 || pc_out !== 64'h0 || taken !== 1'b0 || taken_count !== 2'd0) begin
      fails++; $display("FAIL async_reset got fl %b pc %h tk %b cnt %0d want 0 0 0 0", flush, pc_out, taken, taken_count);
    end
    #3;
    rst_n = 1;
    tick();
    tests++; if (flush !== 1'b0 || fetch_req !== 1'b1 || pc_out !== 64'h0) begin
      fails++; $display("FAIL post_reset got fl %b req %b pc %h want 0 1 0", flush, fetch_req, pc_out);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_cbz();
    test_not_taken();
    test_back_to_back();
    test_wrap();
    test_saturate_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
